// File: rtl/dmem_wait_responder.sv
// Data-memory responder with valid/ready request and response handshakes and a fixed wait-state count.
// Define DMEM_ERR_CHECK_EN to fault misaligned or illegal-size accesses; otherwise they are aligned down.
module dmem_wait_responder #(
   parameter int DMEM_DEPTH      = 1024,
   parameter int DMEM_ADDR_WIDTH = 10,
   parameter int WAIT_CYCLES     = 2
) (
   input  logic        clk,
   input  logic        reset_b,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_notsigned,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = DMEM_ADDR_WIDTH + 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [3:0]      cnt_q;
   logic            lat_write;
   logic [AW-1:0]   lat_addr;
   logic [1:0]      lat_size;
   logic            lat_notsigned;
   logic [31:0]     lat_wdata;

   logic            access;
   logic            fault;
   logic [AW-1:0]   eff_addr;
   logic [1:0]      eff_size;
   logic [DMEM_ADDR_WIDTH-1:0] word_idx;
   logic [31:0]     rd_word;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [31:0]     load_data;
   logic [3:0]      byte_en;
   logic [31:0]     store_word;
   logic            mem_we;

   // Address bits above the word index only wrap the array, so they are deliberately dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^req_addr[31:AW];

   logic [31:0] mem [DMEM_DEPTH];

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      access     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               access  = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Fault detection, or silent alignment when checking is compiled out.
   always_comb begin
      eff_addr = lat_addr;
      eff_size = lat_size;
      fault    = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
      fault = (lat_size == 2'b11) ||
              (lat_size == 2'b01 && lat_addr[0]) ||
              (lat_size == 2'b10 && lat_addr[1:0] != 2'b00);
`else
      if (lat_size == 2'b11) eff_size = 2'b10;
      if (eff_size == 2'b01) eff_addr[0] = 1'b0;
      if (eff_size == 2'b10) eff_addr[1:0] = 2'b00;
`endif
   end

   assign word_idx = eff_addr[AW-1:2];
   assign rd_word  = mem[word_idx];
   assign byte_sel = 8'(rd_word >> {eff_addr[1:0], 3'b000});
   assign half_sel = eff_addr[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      load_data  = rd_word;
      byte_en    = 4'b1111;
      store_word = lat_wdata;
      case (eff_size)
         2'b00: begin
            load_data  = lat_notsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            byte_en    = 4'b0001 << eff_addr[1:0];
            store_word = {4{lat_wdata[7:0]}};
         end
         2'b01: begin
            load_data  = lat_notsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            byte_en    = eff_addr[1] ? 4'b1100 : 4'b0011;
            store_word = {2{lat_wdata[15:0]}};
         end
         default: begin
            load_data  = rd_word;
            byte_en    = 4'b1111;
            store_word = lat_wdata;
         end
      endcase
   end

   assign mem_we = access && lat_write && !fault;

   // The array is intentionally not reset so its contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[word_idx][8*i +: 8] <= store_word[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         cnt_q         <= 4'd0;
         lat_write     <= 1'b0;
         lat_addr      <= '0;
         lat_size      <= 2'b00;
         lat_notsigned <= 1'b0;
         lat_wdata     <= 32'd0;
         resp_rdata    <= 32'd0;
         resp_err      <= 1'b0;
      end else begin
         if (state_q == ST_IDLE && req_valid) begin
            lat_write     <= req_write;
            lat_addr      <= req_addr[AW-1:0];
            lat_size      <= req_size;
            lat_notsigned <= req_notsigned;
            lat_wdata     <= req_wdata;
            cnt_q         <= 4'(WAIT_CYCLES);
         end
         if (state_q == ST_WAIT && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
         end
         if (access) begin
            resp_rdata <= (fault || lat_write) ? 32'd0 : load_data;
            resp_err   <= fault;
         end
      end
   end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Self-checking bench for dmem_wait_responder: directed scenarios plus randomized traffic
// compared against a byte-addressed reference memory model.
module tb_dmem_wait_responder;

   localparam int WAIT_CYCLES = 2;
   localparam int TIMEOUT     = 60;

   logic        clk;
   logic        reset_b;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_notsigned;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int assert_count;
   int fail_count;

   logic [31:0] model_mem [1024];

   dmem_wait_responder #(
      .DMEM_DEPTH(1024),
      .DMEM_ADDR_WIDTH(10),
      .WAIT_CYCLES(WAIT_CYCLES)
   ) dut (
      .clk(clk),
      .reset_b(reset_b),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_addr(req_addr),
      .req_size(req_size),
      .req_notsigned(req_notsigned),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .resp_err(resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: returns {err, rdata} and updates the model memory for stores.
   function automatic logic [32:0] model_op(input logic w, input logic [31:0] a, input logic [1:0] s,
                                             input logic ns, input logic [31:0] wd);
      logic       flt;
      int         idx;
      int         lane;
      logic [31:0] word;
      logic [7:0]  b;
      logic [15:0] h;
      flt = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
      flt = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
`else
      if (s == 2'd3) s = 2'd2;
      if (s == 2'd1) a[0] = 1'b0;
      if (s == 2'd2) a[1:0] = 2'd0;
`endif
      if (flt) return {1'b1, 32'd0};
      idx  = int'(a % 4096) / 4;
      lane = int'(a % 4);
      word = model_mem[idx];
      if (w) begin
         case (s)
            2'd0: word[8*lane +: 8] = wd[7:0];
            2'd1: word[8*lane +: 16] = wd[15:0];
            default: word = wd;
         endcase
         model_mem[idx] = word;
         return {1'b0, 32'd0};
      end
      b = 8'(word >> (8*lane));
      h = 16'(word >> (8*lane));
      case (s)
         2'd0: return {1'b0, ns ? 32'(b) : 32'($signed(b))};
         2'd1: return {1'b0, ns ? 32'(h) : 32'($signed(h))};
         default: return {1'b0, word};
      endcase
   endfunction

   // Drives a request starting at a negedge; returns at the negedge following the accepting edge.
   task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] s, input logic ns,
                        input logic [31:0] wd, output int waited);
      req_valid     = 1'b1;
      req_write     = w;
      req_addr      = a;
      req_size      = s;
      req_notsigned = ns;
      req_wdata     = wd;
      waited = 0;
      while (!req_ready && waited < TIMEOUT) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         assert_count++;
         fail_count++;
         $display("[TB] FAIL accept_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, waited);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_resp(output int lat, output logic [31:0] rd, output logic er);
      lat = 0;
      while (!resp_valid && lat < TIMEOUT) begin
         @(negedge clk);
         lat++;
      end
      if (!resp_valid) begin
         assert_count++;
         fail_count++;
         $display("[TB] FAIL resp_timeout: resp_valid=%0b after %0d cycles, required 1", resp_valid, lat);
      end
      rd = resp_rdata;
      er = resp_err;
   endtask

   task automatic finish_resp(input int delay);
      repeat (delay) @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
   endtask

   // Complete transaction with response taken immediately; latency checked inline by callers.
   task automatic xact(input logic w, input logic [31:0] a, input logic [1:0] s, input logic ns,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
      int waited;
      logic [32:0] unused_exp;
      unused_exp = model_op(w, a, s, ns, wd);
      issue(w, a, s, ns, wd, waited);
      wait_resp(lat, rd, er);
      finish_resp(0);
   endtask

   task automatic test_reset();
      reset_b = 1'b1;
      #2 reset_b = 1'b0;
      repeat (2) @(negedge clk);
      assert_count++;
      if ({req_ready, resp_valid, resp_rdata, resp_err} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
         fail_count++;
         $display("[TB] FAIL reset_values: got ready=%0b valid=%0b rdata=%h err=%0b, required 1 0 0 0",
                  req_ready, resp_valid, resp_rdata, resp_err);
      end
      reset_b = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_word();
      logic [31:0] rd;
      logic er;
      int lat;
      xact(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, rd, er, lat);
      assert_count++;
      if (rd !== 32'd0 || er !== 1'b0 || lat !== WAIT_CYCLES + 1) begin
         fail_count++;
         $display("[TB] FAIL sw_resp: got rdata=%h err=%0b lat=%0d, required 0 0 %0d", rd, er, lat, WAIT_CYCLES + 1);
      end
      xact(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, rd, er, lat);
      assert_count++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== WAIT_CYCLES + 1) begin
         fail_count++;
         $display("[TB] FAIL lw_resp: got rdata=%h err=%0b lat=%0d, required deadbeef 0 %0d", rd, er, lat, WAIT_CYCLES + 1);
      end
   endtask

   task automatic test_extension();
      logic [31:0] rd;
      logic er;
      int lat;
      logic [31:0] addrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
      logic [1:0]  sizes [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
      logic        nsv   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] exps  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
      for (int i = 0; i < 4; i++) begin
         xact(1'b0, addrs[i], sizes[i], nsv[i], 32'h0, rd, er, lat);
         assert_count++;
         if (rd !== exps[i] || er !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL extension_%0d: got rdata=%h err=%0b, required %h 0", i, rd, er, exps[i]);
         end
      end
   endtask

   task automatic test_partial();
      logic [31:0] rd;
      logic er;
      int lat;
      xact(1'b1, 32'h11, 2'd0, 1'b0, 32'hFFFFFF55, rd, er, lat);
      xact(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, rd, er, lat);
      assert_count++;
      if (rd !== 32'hDEAD55EF) begin
         fail_count++;
         $display("[TB] FAIL partial_sb: got %h, required dead55ef", rd);
      end
      xact(1'b1, 32'h12, 2'd1, 1'b0, 32'hABCD1234, rd, er, lat);
      xact(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, rd, er, lat);
      assert_count++;
      if (rd !== 32'h123455EF) begin
         fail_count++;
         $display("[TB] FAIL partial_sh: got %h, required 123455ef", rd);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd;
      logic er;
      int lat;
      int waited;
      logic [32:0] unused_exp;
      unused_exp = model_op(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, waited);
      wait_resp(lat, rd, er);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         assert_count++;
         if (resp_valid !== 1'b1 || resp_rdata !== 32'h123455EF || req_ready !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL backpressure_hold_%0d: got valid=%0b rdata=%h ready=%0b, required 1 123455ef 0",
                     i, resp_valid, resp_rdata, req_ready);
         end
      end
      finish_resp(0);
      assert_count++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         fail_count++;
         $display("[TB] FAIL backpressure_release: got valid=%0b ready=%0b, required 0 1", resp_valid, req_ready);
      end
      unused_exp = model_op(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, waited);
      assert_count++;
      if (waited !== 0 || req_ready !== 1'b0) begin
         fail_count++;
         $display("[TB] FAIL backpressure_next_accept: got waited=%0d ready=%0b, required 0 0", waited, req_ready);
      end
      wait_resp(lat, rd, er);
      finish_resp(0);
   endtask

   task automatic test_misalign();
      logic [31:0] rd;
      logic er;
      int lat;
      xact(1'b0, 32'h12, 2'd2, 1'b0, 32'h0, rd, er, lat);
`ifdef DMEM_ERR_CHECK_EN
      assert_count++;
      if (rd !== 32'd0 || er !== 1'b1 || lat !== WAIT_CYCLES + 1) begin
         fail_count++;
         $display("[TB] FAIL misalign_lw: got rdata=%h err=%0b lat=%0d, required 0 1 %0d", rd, er, lat, WAIT_CYCLES + 1);
      end
      xact(1'b1, 32'h11, 2'd1, 1'b0, 32'h00007777, rd, er, lat);
      assert_count++;
      if (er !== 1'b1) begin
         fail_count++;
         $display("[TB] FAIL misalign_sh_err: got err=%0b, required 1", er);
      end
      xact(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, rd, er, lat);
      assert_count++;
      if (rd !== 32'h123455EF) begin
         fail_count++;
         $display("[TB] FAIL misalign_no_write: got %h, required 123455ef", rd);
      end
      xact(1'b1, 32'h10, 2'd2, 1'b0, 32'hA5A5A5A5, rd, er, lat);
      xact(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, rd, er, lat);
      assert_count++;
      if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin
         fail_count++;
         $display("[TB] FAIL misalign_followup: got rdata=%h err=%0b, required a5a5a5a5 0", rd, er);
      end
`else
      assert_count++;
      if (rd !== 32'h123455EF || er !== 1'b0) begin
         fail_count++;
         $display("[TB] FAIL misalign_lw: got rdata=%h err=%0b, required 123455ef 0", rd, er);
      end
      xact(1'b0, 32'h11, 2'd3, 1'b0, 32'h0, rd, er, lat);
      assert_count++;
      if (rd !== 32'h123455EF || er !== 1'b0) begin
         fail_count++;
         $display("[TB] FAIL size3_as_word: got rdata=%h err=%0b, required 123455ef 0", rd, er);
      end
`endif
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic er;
      int lat;
      int waited;
      xact(1'b1, 32'h20, 2'd2, 1'b0, 32'h11111111, rd, er, lat);
      issue(1'b1, 32'h20, 2'd2, 1'b0, 32'hCAFEF00D, waited);
      reset_b = 1'b0;
      #1;
      assert_count++;
      if ({req_ready, resp_valid, resp_rdata, resp_err} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
         fail_count++;
         $display("[TB] FAIL reset_mid_values: got ready=%0b valid=%0b rdata=%h err=%0b, required 1 0 0 0",
                  req_ready, resp_valid, resp_rdata, resp_err);
      end
      @(negedge clk);
      reset_b = 1'b1;
      repeat (4) @(negedge clk);
      assert_count++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         fail_count++;
         $display("[TB] FAIL reset_mid_idle: got valid=%0b ready=%0b, required 0 1", resp_valid, req_ready);
      end
      xact(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, rd, er, lat);
      assert_count++;
      if (rd !== 32'h11111111) begin
         fail_count++;
         $display("[TB] FAIL reset_mid_no_write: got %h, required 11111111", rd);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd;
      logic er;
      int lat;
      int waited;
      logic [32:0] exp_v;
      logic        w;
      logic [31:0] a;
      logic [31:0] wd;
      logic [1:0]  s;
      logic        ns;
      for (int i = 0; i < 16; i++) begin
         xact(1'b1, 32'h100 + 32'(4*i), 2'd2, 1'b0, $urandom(), rd, er, lat);
      end
      for (int i = 0; i < 40; i++) begin
         w  = 1'($urandom_range(0, 1));
         a  = ($urandom() & 32'hFFFF_F000) | (32'h100 + 32'($urandom_range(0, 63)));
         s  = 2'($urandom_range(0, 3));
         ns = 1'($urandom_range(0, 1));
         wd = $urandom();
         exp_v = model_op(w, a, s, ns, wd);
         issue(w, a, s, ns, wd, waited);
         wait_resp(lat, rd, er);
         assert_count++;
         if ({er, rd} !== exp_v || lat !== WAIT_CYCLES + 1) begin
            fail_count++;
            $display("[TB] FAIL random_%0d: w=%0b a=%h s=%0d ns=%0b got err=%0b rdata=%h lat=%0d, required err=%0b rdata=%h lat=%0d",
                     i, w, a, s, ns, er, rd, lat, exp_v[32], exp_v[31:0], WAIT_CYCLES + 1);
         end
         finish_resp($urandom_range(0, 3));
      end
   endtask

   initial begin
      assert_count  = 0;
      fail_count    = 0;
      reset_b       = 1'b1;
      req_valid     = 1'b0;
      req_write     = 1'b0;
      req_addr      = 32'd0;
      req_size      = 2'd0;
      req_notsigned = 1'b0;
      req_wdata     = 32'd0;
      resp_ready    = 1'b0;
      for (int i = 0; i < 1024; i++) model_mem[i] = 32'd0;
      test_reset();
      test_word();
      test_extension();
      test_partial();
      test_backpressure();
      test_misalign();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
